pwm_cfg_sequencer: RTL

Bus master in front of the PWM register file. It owns the file's read/write/addr/data_write port and shares it between two requesters:
- a host byte-access port, for single reads and writes;
- an atomic update engine, which reprograms a complete PWM configuration in a safe order: disable, load, counter reset, re-enable.

It sits between the SPI/host decoder and the register file.

---
 rtl/pwm_cfg_sequencer_if.sv | 12 +
 rtl/pwm_cfg_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_cfg_sequencer_if.sv
// Register-file access bus driven by pwm_cfg_sequencer.
// The master drives the strobes, address and write data; the slave returns read data combinationally.
interface pwm_cfg_sequencer_if;
   logic       read;
   logic       write;
   logic [5:0] addr;
   logic [7:0] data_write;
   logic [7:0] data_read;

   modport master (output read, write, addr, data_write, input data_read);
   modport slave  (input read, write, addr, data_write, output data_read);
endinterface

// File: rtl/pwm_cfg_sequencer.sv
// Arbitrates the PWM register-file bus between single host byte accesses and an atomic
// 14-write update engine (disable, load, counter reset, re-enable).
module pwm_cfg_sequencer #(
   parameter int unsigned GAP_CYCLES = 0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       host_req,
   input  logic                       host_we,
   input  logic [5:0]                 host_addr,
   input  logic [7:0]                 host_wdata,
   output logic                       host_gnt,
   output logic [7:0]                 host_rdata,
   output logic                       host_rvalid,
   input  logic                       upd_start,
   input  logic [15:0]                upd_period,
   input  logic [15:0]                upd_cmp1,
   input  logic [15:0]                upd_cmp2,
   input  logic [7:0]                 upd_prescale,
   input  logic [7:0]                 upd_functions,
   input  logic                       upd_dir,
   input  logic                       upd_pwm_en,
   input  logic                       upd_cnt_en,
   output logic                       upd_busy,
   output logic                       upd_done,
   output logic                       upd_err,
   pwm_cfg_sequencer_if.master        rf
);

   typedef enum logic [2:0] {IDLE, HOST, UPD_WR, UPD_GAP, DONE} state_e;

   typedef struct packed {
      logic [15:0] period;
      logic [15:0] cmp1;
      logic [15:0] cmp2;
      logic [7:0]  prescale;
      logic [7:0]  functions;
      logic        dir;
      logic        pwm_en;
      logic        cnt_en;
   } cfg_t;

   localparam logic [3:0] LAST_STEP = 4'd13;
   localparam logic [3:0] GAP_LAST  = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

   // {addr, data} for each update step; the order keeps the PWM disabled while it is reloaded.
   function automatic logic [13:0] step_word(input logic [3:0] step, input cfg_t c);
      case (step)
         4'd0:    step_word = {6'h02, 8'h00};
         4'd1:    step_word = {6'h0C, 8'h00};
         4'd2:    step_word = {6'h00, c.period[7:0]};
         4'd3:    step_word = {6'h01, c.period[15:8]};
         4'd4:    step_word = {6'h03, c.cmp1[7:0]};
         4'd5:    step_word = {6'h04, c.cmp1[15:8]};
         4'd6:    step_word = {6'h05, c.cmp2[7:0]};
         4'd7:    step_word = {6'h06, c.cmp2[15:8]};
         4'd8:    step_word = {6'h0A, c.prescale};
         4'd9:    step_word = {6'h0B, 7'b0, c.dir};
         4'd10:   step_word = {6'h0D, c.functions};
         4'd11:   step_word = {6'h07, 8'h00};
         4'd12:   step_word = {6'h0C, 7'b0, c.pwm_en};
         4'd13:   step_word = {6'h02, 7'b0, c.cnt_en};
         default: step_word = 14'h0;
      endcase
   endfunction

   state_e     state_q, state_d;
   logic [3:0] step_q, step_d;
   logic [3:0] gap_q, gap_d;
   cfg_t       cfg_q, cfg_d;
   logic       read_q, read_d, write_q, write_d;
   logic [5:0] addr_q, addr_d;
   logic [7:0] wdata_q, wdata_d, rdata_q, rdata_d;
   logic       gnt_q, gnt_d, rvalid_q, rvalid_d;
   logic       busy_q, busy_d, done_q, done_d, err_q, err_d;

   // NOTE: every flop uses <= so all state advances together on the edge, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         step_q   <= '0;
         gap_q    <= '0;
         cfg_q    <= '0;
         read_q   <= 1'b0;
         write_q  <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         gnt_q    <= 1'b0;
         rvalid_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         step_q   <= step_d;
         gap_q    <= gap_d;
         cfg_q    <= cfg_d;
         read_q   <= read_d;
         write_q  <= write_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         gnt_q    <= gnt_d;
         rvalid_q <= rvalid_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   // NOTE: defaults first so every path assigns every signal and no latch is inferred.
   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      gap_d   = gap_q;
      cfg_d   = cfg_q;
      case (state_q)
         IDLE: begin
            if (upd_start) begin
               state_d = UPD_WR;
               step_d  = '0;
               gap_d   = '0;
               cfg_d   = '{period: upd_period, cmp1: upd_cmp1, cmp2: upd_cmp2,
                           prescale: upd_prescale, functions: upd_functions,
                           dir: upd_dir, pwm_en: upd_pwm_en, cnt_en: upd_cnt_en};
            end else if (host_req) begin
               state_d = HOST;
            end
         end
         HOST: state_d = IDLE;
         UPD_WR: begin
            if (step_q == LAST_STEP) begin
               state_d = DONE;
            end else if (GAP_CYCLES == 0) begin
               step_d = step_q + 4'd1;
            end else begin
               state_d = UPD_GAP;
               gap_d   = '0;
            end
         end
         UPD_GAP: begin
            if (gap_q == GAP_LAST) begin
               state_d = UPD_WR;
               step_d  = step_q + 4'd1;
               gap_d   = '0;
            end else begin
               gap_d = gap_q + 4'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
            step_d  = '0;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered, so they are derived from the state being entered.
   always_comb begin
      read_d   = 1'b0;
      write_d  = 1'b0;
      addr_d   = '0;
      wdata_d  = '0;
      gnt_d    = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      err_d    = upd_start && (state_q != IDLE);
      rvalid_d = (state_q == HOST) && read_q;
      rdata_d  = rvalid_d ? rf.data_read : rdata_q;
      case (state_d)
         HOST: begin
            gnt_d   = 1'b1;
            addr_d  = host_addr;
            write_d = host_we;
            read_d  = !host_we;
            wdata_d = host_we ? host_wdata : 8'h00;
         end
         UPD_WR: begin
            write_d           = 1'b1;
            busy_d            = 1'b1;
            {addr_d, wdata_d} = step_word(step_d, cfg_d);
         end
         UPD_GAP: busy_d = 1'b1;
         DONE:    done_d = 1'b1;
         default: ;
      endcase
   end

   assign rf.read       = read_q;
   assign rf.write      = write_q;
   assign rf.addr       = addr_q;
   assign rf.data_write = wdata_q;
   assign host_gnt      = gnt_q;
   assign host_rdata    = rdata_q;
   assign host_rvalid   = rvalid_q;
   assign upd_busy      = busy_q;
   assign upd_done      = done_q;
   assign upd_err       = err_q;

endmodule
